// File: rtl/jetpack_physics.sv
// Per-frame vertical physics for a jetpack sprite: synchronized thrust, signed velocity, clamped position.
// Optional airborne frame counter is built only when FLIGHT_TIME_EN is defined.
module jetpack_physics #(
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 400,
  parameter int GRAVITY = 1,
  parameter int THRUST  = 2,
  parameter int VMAX    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              thrust,
  input  logic              freeze,
  output logic [10:0]       y,
  output logic signed [4:0] vel,
  output logic [1:0]        state,
  output logic              at_ceiling,
  output logic              pos_valid,
  output logic [13:0]       flight_frames
);

  typedef enum logic [1:0] {
    ST_GROUNDED = 2'd0,
    ST_RISING   = 2'd1,
    ST_FALLING  = 2'd2
  } state_t;

  localparam logic signed [6:0]  LP_VMAX   = 7'(VMAX);
  localparam logic signed [6:0]  LP_VMIN   = 7'(-VMAX);
  localparam logic signed [6:0]  LP_THRUST = 7'(THRUST);
  localparam logic signed [6:0]  LP_GRAV   = 7'(GRAVITY);
  localparam logic signed [11:0] LP_YMAX   = 12'(Y_MAX);
  localparam logic signed [11:0] LP_YMIN   = 12'(Y_MIN);

  logic              r_thrust_meta;
  logic              r_thrust_sync;
  logic [10:0]       r_y;
  logic signed [4:0] r_vel;
  state_t            r_state;
  logic              r_at_ceiling;
  logic              r_pos_valid;

  logic              w_update;
  logic signed [6:0] w_vel_cur;
  logic signed [6:0] w_vel_sum;
  logic signed [6:0] w_vel_n;
  logic signed [11:0] w_yt;
  logic [10:0]       w_y_n;
  logic signed [4:0] w_vel_c;
  state_t            w_state_n;

  assign w_update = frame_tick & ~freeze;

  always_comb begin
    w_vel_cur = {{2{r_vel[4]}}, r_vel};
    w_vel_sum = '0;
    w_vel_n   = '0;
    if (r_thrust_sync) begin
      w_vel_sum = w_vel_cur - LP_THRUST;
      w_vel_n   = (w_vel_sum < LP_VMIN) ? LP_VMIN : w_vel_sum;
    end else begin
      w_vel_sum = w_vel_cur + LP_GRAV;
      w_vel_n   = (w_vel_sum > LP_VMAX) ? LP_VMAX : w_vel_sum;
    end

    // 12-bit signed sum so a climb past the top edge shows up as negative, not a wrap
    w_yt    = $signed({1'b0, r_y}) + $signed({{5{w_vel_n[6]}}, w_vel_n});
    w_y_n   = w_yt[10:0];
    w_vel_c = w_vel_n[4:0];
    if (w_yt >= LP_YMAX) begin
      w_y_n   = 11'(Y_MAX);
      w_vel_c = '0;
    end else if (w_yt <= LP_YMIN) begin
      w_y_n   = 11'(Y_MIN);
      w_vel_c = '0;
    end

    if ((w_y_n == 11'(Y_MAX)) && (w_vel_c == 5'sd0)) begin
      w_state_n = ST_GROUNDED;
    end else if (w_vel_c < 5'sd0) begin
      w_state_n = ST_RISING;
    end else begin
      w_state_n = ST_FALLING;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_thrust_meta <= 1'b0;
      r_thrust_sync <= 1'b0;
      r_y           <= 11'(Y_MAX);
      r_vel         <= '0;
      r_state       <= ST_GROUNDED;
      r_at_ceiling  <= 1'b0;
      r_pos_valid   <= 1'b0;
    end else begin
      r_thrust_meta <= thrust;
      r_thrust_sync <= r_thrust_meta;
      r_pos_valid   <= w_update;
      if (w_update) begin
        r_y          <= w_y_n;
        r_vel        <= w_vel_c;
        r_state      <= w_state_n;
        r_at_ceiling <= (w_y_n == 11'(Y_MIN));
      end
    end
  end

`ifdef FLIGHT_TIME_EN
  logic [13:0] r_flight;

  // Takeoff restarts the count; landing leaves the last flight's count on display
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flight <= '0;
    end else if (w_update) begin
      if ((r_state == ST_GROUNDED) && (w_state_n != ST_GROUNDED)) begin
        r_flight <= '0;
      end else if ((w_state_n != ST_GROUNDED) && (r_flight != 14'd9999)) begin
        r_flight <= r_flight + 14'd1;
      end
    end
  end

  assign flight_frames = r_flight;
`else
  assign flight_frames = '0;
`endif

  assign y          = r_y;
  assign vel        = r_vel;
  assign state      = r_state;
  assign at_ceiling = r_at_ceiling;
  assign pos_valid  = r_pos_valid;

endmodule

// File: tb/tb_jetpack_physics.sv
// Scoreboard bench for jetpack_physics: expected results are queued at each frame tick and checked on pos_valid.
module tb_jetpack_physics;

  logic              clk;
  logic              rst;
  logic              frame_tick;
  logic              thrust;
  logic              freeze;
  logic [10:0]       y;
  logic signed [4:0] vel;
  logic [1:0]        state;
  logic              at_ceiling;
  logic              pos_valid;
  logic [13:0]       flight_frames;

  jetpack_physics dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .thrust(thrust), .freeze(freeze),
    .y(y), .vel(vel), .state(state), .at_ceiling(at_ceiling), .pos_valid(pos_valid),
    .flight_frames(flight_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    int vel;
    int st;
    int ceil;
    int ff;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int m_y, m_vel, m_st, m_ff;

  task automatic model_reset();
    m_y = 400; m_vel = 0; m_st = 0; m_ff = 0;
  endtask

  task automatic model_step(input bit th);
    int v, yt, prev;
    prev = m_st;
    if (th) begin
      v = m_vel - 2;
      if (v < -8) v = -8;
    end else begin
      v = m_vel + 1;
      if (v > 8) v = 8;
    end
    yt = m_y + v;
    if (yt >= 400) begin
      m_y = 400; v = 0;
    end else if (yt <= 0) begin
      m_y = 0; v = 0;
    end else begin
      m_y = yt;
    end
    m_vel = v;
    if (m_y == 400 && m_vel == 0) m_st = 0;
    else if (m_vel < 0) m_st = 1;
    else m_st = 2;
`ifdef FLIGHT_TIME_EN
    if (prev == 0 && m_st != 0) m_ff = 0;
    else if (m_st != 0 && m_ff < 9999) m_ff++;
`else
    if (prev < 0) m_ff = 0;
`endif
  endtask

  // One frame update: settle thrust through the synchronizer, pulse frame_tick, check the queued result.
  task automatic tick(input bit th);
    exp_t e;
    @(negedge clk);
    thrust = th;
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    model_step(th);
    e.y = m_y; e.vel = m_vel; e.st = m_st; e.ceil = (m_y == 0) ? 1 : 0; e.ff = m_ff;
    sb.push_back(e);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    total++;
    if (pos_valid !== 1'b1) begin bad++; $display("FAIL pos_valid_pulse: got %b want 1", pos_valid); end
    e = sb.pop_front();
    total++;
    if (int'(y) !== e.y) begin bad++; $display("FAIL tick_y: got %0d want %0d", y, e.y); end
    total++;
    if (int'(vel) !== e.vel) begin bad++; $display("FAIL tick_vel: got %0d want %0d", vel, e.vel); end
    total++;
    if (int'(state) !== e.st) begin bad++; $display("FAIL tick_state: got %0d want %0d", state, e.st); end
    total++;
    if (int'(at_ceiling) !== e.ceil) begin bad++; $display("FAIL tick_ceiling: got %0d want %0d", at_ceiling, e.ceil); end
    total++;
    if (int'(flight_frames) !== e.ff) begin bad++; $display("FAIL tick_flight: got %0d want %0d", flight_frames, e.ff); end
    $display("txn thrust=%0d y=%0d vel=%0d state=%0d ceil=%0d ff=%0d", th, y, vel, state, at_ceiling, flight_frames);
    @(posedge clk); #1;
    total++;
    if (pos_valid !== 1'b0) begin bad++; $display("FAIL pos_valid_width: got %b want 0", pos_valid); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; thrust = 1'b0; frame_tick = 1'b0; freeze = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (y !== 11'd400) begin bad++; $display("FAIL reset_y: got %0d want 400", y); end
    total++;
    if (vel !== 5'sd0) begin bad++; $display("FAIL reset_vel: got %0d want 0", vel); end
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++;
    if (pos_valid !== 1'b0 || at_ceiling !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got pv=%b ceil=%b want 0 0", pos_valid, at_ceiling);
    end
    total++;
    if (flight_frames !== 14'd0) begin bad++; $display("FAIL reset_flight: got %0d want 0", flight_frames); end
    $display("txn reset y=%0d vel=%0d state=%0d", y, vel, state);
  endtask

  task automatic test_takeoff();
    int ev[3] = '{-2, -4, -6};
    int ey[3] = '{398, 394, 388};
    for (int k = 0; k < 3; k++) begin
      tick(1'b1);
      total++;
      if (int'(vel) !== ev[k] || int'(y) !== ey[k] || state !== 2'd1) begin
        bad++;
        $display("FAIL takeoff_%0d: got vel=%0d y=%0d st=%0d want vel=%0d y=%0d st=1", k, vel, y, state, ev[k], ey[k]);
      end
    end
  endtask

  task automatic test_apex();
    int ev;
    for (int k = 0; k < 7; k++) begin
      ev = -5 + k;
      tick(1'b0);
      total++;
      if (int'(vel) !== ev || int'(state) !== ((ev < 0) ? 1 : 2)) begin
        bad++;
        $display("FAIL apex_%0d: got vel=%0d st=%0d want vel=%0d st=%0d", k, vel, state, ev, (ev < 0) ? 1 : 2);
      end
    end
  endtask

  task automatic test_ceiling();
    bit hit;
    int vmin;
    do_reset();
    hit = 1'b0; vmin = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      tick(1'b1);
      if (at_ceiling) hit = 1'b1;
      else if (int'(vel) < vmin) vmin = int'(vel);
    end
    total++;
    if (!hit) begin bad++; $display("FAIL ceiling_timeout: got at_ceiling=0 want 1 within 100 ticks"); end
    total++;
    if (vmin !== -8) begin bad++; $display("FAIL ceiling_vsat: got min vel %0d want -8", vmin); end
    total++;
    if (y !== 11'd0 || vel !== 5'sd0 || state !== 2'd2) begin
      bad++; $display("FAIL ceiling_clamp: got y=%0d vel=%0d st=%0d want 0 0 2", y, vel, state);
    end
    tick(1'b1);
  endtask

  task automatic test_landing();
    bit landed;
    int ev, ff_hold;
    landed = 1'b0;
    for (int k = 1; k < 100 && !landed; k++) begin
      tick(1'b0);
      if (state == 2'd0) begin
        landed = 1'b1;
      end else begin
        ev = (k > 8) ? 8 : k;
        total++;
        if (int'(vel) !== ev) begin bad++; $display("FAIL fall_vel_%0d: got %0d want %0d", k, vel, ev); end
      end
    end
    total++;
    if (!landed) begin bad++; $display("FAIL landing_timeout: got state=%0d want 0 within 100 ticks", state); end
    total++;
    if (y !== 11'd400 || vel !== 5'sd0) begin bad++; $display("FAIL landing_clamp: got y=%0d vel=%0d want 400 0", y, vel); end
    ff_hold = int'(flight_frames);
    tick(1'b0);
    total++;
    if (int'(flight_frames) !== ff_hold || state !== 2'd0 || y !== 11'd400) begin
      bad++; $display("FAIL grounded_hold: got ff=%0d st=%0d y=%0d want ff=%0d st=0 y=400", flight_frames, state, y, ff_hold);
    end
`ifndef FLIGHT_TIME_EN
    total++;
    if (flight_frames !== 14'd0) begin bad++; $display("FAIL flight_disabled: got %0d want 0", flight_frames); end
`endif
  endtask

  task automatic test_freeze_reset();
    logic [10:0] hy;
    logic signed [4:0] hv;
    for (int k = 0; k < 3; k++) tick(1'b1);
    hy = y; hv = vel;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      freeze = 1'b1; frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      @(posedge clk); #1;
      total++;
      if (pos_valid !== 1'b0 || y !== hy || vel !== hv || state !== 2'd1) begin
        bad++; $display("FAIL freeze_%0d: got pv=%b y=%0d vel=%0d st=%0d want pv=0 y=%0d vel=%0d st=1", k, pos_valid, y, vel, state, hy, hv);
      end
      $display("txn freeze tick y=%0d vel=%0d", y, vel);
    end
    @(negedge clk);
    freeze = 1'b0; thrust = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; frame_tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; frame_tick = 1'b0;
    model_reset();
    total++;
    if (y !== 11'd400 || vel !== 5'sd0 || state !== 2'd0 || pos_valid !== 1'b0 || at_ceiling !== 1'b0 || flight_frames !== 14'd0) begin
      bad++; $display("FAIL reset_over_tick: got y=%0d vel=%0d st=%0d pv=%b ff=%0d want 400 0 0 0 0", y, vel, state, pos_valid, flight_frames);
    end
    @(posedge clk); #1;
    total++;
    if (pos_valid !== 1'b0 || y !== 11'd400) begin
      bad++; $display("FAIL reset_after: got pv=%b y=%0d want 0 400", pos_valid, y);
    end
    $display("txn reset_with_tick y=%0d vel=%0d state=%0d", y, vel, state);
    thrust = 1'b0;
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; thrust = 1'b0; freeze = 1'b0;
    model_reset();
    test_reset();
    test_takeoff();
    test_apex();
    test_ceiling();
    test_landing();
    test_freeze_reset();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jetpack_physics.md
JETPACK_PHYSICS -- requirements
Module: jetpack_physics

Interface
REQ-001 Parameters SHALL be, one per line:
- Y_MIN, 0, top clamp for player y in pixels.
- Y_MAX, 400, ground clamp for player y; the 75-pixel sprite bottom stays at or above line 475.
- GRAVITY, 1, downward velocity increment per frame.
- THRUST, 2, upward velocity increment per frame while thrust is held.
- VMAX, 8, velocity magnitude limit in both directions.

REQ-002 Ports SHALL be, one per line (clock and reset first):
- clk, in, 1, 100 MHz system clock.
- rst, in, 1, synchronous active-low reset.
- frame_tick, in, 1, one-clk pulse per video frame.
- thrust, in, 1, asynchronous jetpack button.
- freeze, in, 1, pause; frame_tick is ignored while high.
- y, out, 11, player top-edge row, consumed by the display stage.
- vel, out, 5, signed velocity; positive means downward.
- state, out, 2, 0=GROUNDED, 1=RISING, 2=FALLING.
- at_ceiling, out, 1, high while y==Y_MIN.
- pos_valid, out, 1, one-clk pulse when y/vel are updated.
- flight_frames, out, 14, airborne frame count for BCD display.

REQ-003 The design SHALL use one clock; every register SHALL be clocked by clk with no derived clocks.

Function
REQ-004 thrust SHALL pass through a 2-flop synchronizer; the update uses the synchronized value present in the frame_tick cycle.
REQ-005 An update SHALL occur only in cycles where frame_tick=1, freeze=0 and rst=1.
REQ-006 Velocity rule: thrust held -> vel_n = max(vel-THRUST, -VMAX); thrust released -> vel_n = min(vel+GRAVITY, +VMAX); arithmetic is signed.
REQ-007 Position rule: yt = y + vel_n, computed 12-bit signed with no wrap-around.
REQ-008 Ground clamp: if yt >= Y_MAX, then y=Y_MAX and vel=0.
REQ-009 Ceiling clamp: if yt <= Y_MIN (including negative values), then y=Y_MIN and vel=0.
REQ-010 Otherwise y=yt and vel=vel_n.
REQ-011 y, vel, state and at_ceiling SHALL update on the clk edge ending the frame_tick cycle (latency 1).
REQ-012 pos_valid SHALL be high for exactly that following cycle; it SHALL NOT pulse on ignored ticks.
REQ-013 state SHALL be derived from the post-update values:
- GROUNDED if y==Y_MAX and vel==0.
- RISING if vel<0.
- FALLING otherwise, including a ceiling clamp with vel==0.
REQ-014 GROUNDED with thrust released SHALL stay GROUNDED: yt=Y_MAX+1 clamps back to Y_MAX.
REQ-015 at_ceiling SHALL equal (y==Y_MIN), registered alongside y.
REQ-016 Outputs SHALL hold their values between updates; freeze held high SHALL hold all state indefinitely.

Reset
REQ-017 When rst==0 at a clk edge:
- y=Y_MAX, vel=0, state=GROUNDED.
- at_ceiling=0, pos_valid=0, flight_frames=0.
- Synchronizer flops cleared.
REQ-018 Reset SHALL win over a simultaneous frame_tick; mid-flight reset SHALL restore the reset values on that edge.

Configuration
REQ-019 With macro FLIGHT_TIME_EN defined, flight_frames SHALL behave as follows:
- Clears to 0 on an update that leaves GROUNDED.
- Increments by 1 on each update whose resulting state is not GROUNDED, saturating at 9999.
- Holds its value after landing.
REQ-020 Without FLIGHT_TIME_EN, flight_frames SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-021 Reset: drive rst=0 for 2 clk -> y=400, vel=0, state=0, pos_valid=0, flight_frames=0.
REQ-022 Takeoff: from ground, thrust held for 3 ticks -> vel -2,-4,-6; y 398,394,388; state=1; pos_valid pulses once per tick, 1 clk after each tick.
REQ-023 Apex: from the REQ-022 state, release thrust and apply ticks -> vel -5,-4,...,0 then +1; state changes to 2 on the tick where vel becomes >=0.
REQ-024 Ceiling: hold thrust from ground -> vel saturates at -8; the tick where yt<=0 gives y=0, vel=0, at_ceiling=1, state=2.
REQ-025 Landing: from y=0, vel=0 free fall -> vel 1..8 then stays 8; the tick where yt>=400 gives y=400, vel=0, state=0. With FLIGHT_TIME_EN, flight_frames stops and holds its count; without it, flight_frames stays 0.
REQ-026 Freeze and reset: freeze=1 with 5 ticks -> no change, no pos_valid. Then rst=0 in the same cycle as a tick while mid-flight -> reset values only.
